// File: rtl/ray_sched.sv
// Ray launch scheduler: walks the per-frame ray grid, launches one march per
// MARCH_CLKS clocks while active, and turns tester results into 8-bit shades.
module ray_sched #(
    parameter int unsigned MARCH_CLKS = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               frame_start,
    input  logic               line_start,
    input  logic               active,
    input  logic signed [15:0] cx,
    input  logic signed [15:0] cy,
    input  logic signed [15:0] cz,
    input  logic signed [15:0] bx,
    input  logic signed [15:0] by,
    input  logic signed [15:0] bz,
    input  logic signed [15:0] ux,
    input  logic signed [15:0] uy,
    input  logic signed [15:0] uz,
    input  logic signed [15:0] vx,
    input  logic signed [15:0] vy,
    input  logic signed [15:0] vz,
    output logic               march_start,
    output logic signed [15:0] px,
    output logic signed [15:0] py,
    output logic signed [15:0] pz,
    output logic signed [15:0] rx,
    output logic signed [15:0] ry,
    output logic signed [15:0] rz,
    input  logic               hit_in,
    input  logic signed [15:0] light_in,
    output logic [7:0]         shade,
    output logic               shade_valid
);

    localparam logic [3:0] LAST_PHASE = 4'(MARCH_CLKS - 1);

    typedef enum logic {
        S_IDLE,
        S_MARCH
    } state_t;

    state_t             r_state;
    logic [3:0]         r_phase;
    logic               r_armed;
    logic signed [15:0] r_ux, r_uy, r_uz;
    logic signed [15:0] r_vx, r_vy, r_vz;
    logic signed [15:0] r_row_x, r_row_y, r_row_z;
    logic signed [15:0] r_ray_x, r_ray_y, r_ray_z;
    logic [7:0]         w_shade;

    // Clamp the tester's signed light value into the 0..255 pixel range.
    always_comb begin
        w_shade = 8'd0;
        if (hit_in) begin
            if (light_in < 16'sd0)
                w_shade = 8'd0;
            else if (light_in > 16'sd255)
                w_shade = 8'd255;
            else
                w_shade = light_in[7:0];
        end
    end

    // Phase counts 0..MARCH_CLKS-1 starting in the launch cycle, so the
    // capture/relaunch edge falls exactly MARCH_CLKS clocks after a launch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_phase     <= 4'd0;
            r_armed     <= 1'b0;
            r_ux        <= 16'sd0;
            r_uy        <= 16'sd0;
            r_uz        <= 16'sd0;
            r_vx        <= 16'sd0;
            r_vy        <= 16'sd0;
            r_vz        <= 16'sd0;
            r_row_x     <= 16'sd0;
            r_row_y     <= 16'sd0;
            r_row_z     <= 16'sd0;
            r_ray_x     <= 16'sd0;
            r_ray_y     <= 16'sd0;
            r_ray_z     <= 16'sd0;
            px          <= 16'sd0;
            py          <= 16'sd0;
            pz          <= 16'sd0;
            rx          <= 16'sd0;
            ry          <= 16'sd0;
            rz          <= 16'sd0;
            march_start <= 1'b0;
            shade       <= 8'd0;
            shade_valid <= 1'b0;
        end else begin
            march_start <= 1'b0;
            shade_valid <= 1'b0;
            if (frame_start) begin
                px      <= cx;
                py      <= cy;
                pz      <= cz;
                r_ux    <= ux;
                r_uy    <= uy;
                r_uz    <= uz;
                r_vx    <= vx;
                r_vy    <= vy;
                r_vz    <= vz;
                r_row_x <= bx;
                r_row_y <= by;
                r_row_z <= bz;
                r_ray_x <= bx;
                r_ray_y <= by;
                r_ray_z <= bz;
                r_state <= S_IDLE;
                r_phase <= 4'd0;
                r_armed <= 1'b1;
            end else if (line_start) begin
                r_ray_x <= r_row_x;
                r_ray_y <= r_row_y;
                r_ray_z <= r_row_z;
                r_row_x <= r_row_x + r_vx;
                r_row_y <= r_row_y + r_vy;
                r_row_z <= r_row_z + r_vz;
                r_state <= S_IDLE;
                r_phase <= 4'd0;
                r_armed <= 1'b1;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_phase <= 4'd0;
                        if (r_armed && active) begin
                            march_start <= 1'b1;
                            rx          <= r_ray_x;
                            ry          <= r_ray_y;
                            rz          <= r_ray_z;
                            r_ray_x     <= r_ray_x + r_ux;
                            r_ray_y     <= r_ray_y + r_uy;
                            r_ray_z     <= r_ray_z + r_uz;
                            r_state     <= S_MARCH;
                        end
                    end
                    S_MARCH: begin
                        if (r_phase == LAST_PHASE) begin
                            shade_valid <= 1'b1;
                            shade       <= w_shade;
                            r_phase     <= 4'd0;
                            if (active) begin
                                march_start <= 1'b1;
                                rx          <= r_ray_x;
                                ry          <= r_ray_y;
                                rz          <= r_ray_z;
                                r_ray_x     <= r_ray_x + r_ux;
                                r_ray_y     <= r_ray_y + r_uy;
                                r_ray_z     <= r_ray_z + r_uz;
                            end else begin
                                r_state <= S_IDLE;
                            end
                        end else begin
                            r_phase <= r_phase + 4'd1;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_phase <= 4'd0;
                    end
                endcase
            end
        end
    end

endmodule
